// File: rtl/store_axi_writer_if.sv
// AXI4 write-channel bundle (AW, W, B) between store_axi_writer (master) and the interconnect (slave).
interface store_axi_writer_if #(
  parameter int ID_W = 4
);
  logic [ID_W-1:0] AWID;
  logic [31:0]     AWADDR;
  logic [3:0]      AWLEN;
  logic [2:0]      AWSIZE;
  logic [1:0]      AWBURST;
  logic            AWVALID;
  logic            AWREADY;
  logic [31:0]     WDATA;
  logic [3:0]      WSTRB;
  logic            WLAST;
  logic            WVALID;
  logic            WREADY;
  logic [ID_W-1:0] BID;
  logic [1:0]      BRESP;
  logic            BVALID;
  logic            BREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY
  );

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY
  );
endinterface

// File: rtl/store_axi_writer.sv
// CPU store (SB/SH/SW) to one single-beat AXI4 write: byte-lane placement, WSTRB and AW/W/B sequencing.
// Optional macro STORE_MISALIGN_TRAP_EN: misaligned SH/SW are trapped (done+err) instead of written.
module store_axi_writer #(
  parameter int              ID_W      = 4,
  parameter logic [ID_W-1:0] MASTER_ID = ID_W'(1'b1)
) (
  input  logic               ACLK,
  input  logic               ARESETn,
  input  logic               st_req,
  input  logic [31:0]        st_addr,
  input  logic [31:0]        st_data,
  input  logic [2:0]         st_func3,
  output logic               st_ready,
  output logic               st_done,
  output logic               st_err,
  store_axi_writer_if.master axi
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_AW_W = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
`ifdef STORE_MISALIGN_TRAP_EN
  localparam logic [1:0] S_TRAP = 2'd3;
`endif

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;

  function automatic logic [3:0] lane_strb(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] s;
    case (f3)
      F3_SB:   s = 4'b0001 << a;
      F3_SH:   s = a[1] ? 4'b1100 : 4'b0011;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    case (f3)
      F3_SB:   r = {4{d[7:0]}};
      F3_SH:   r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

`ifdef STORE_MISALIGN_TRAP_EN
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    logic m;
    case (f3)
      F3_SB:   m = 1'b0;
      F3_SH:   m = a[0];
      default: m = (a != 2'b00);
    endcase
    return m;
  endfunction
`endif

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic        r_aw_done;
  logic        r_w_done;
  logic [31:0] r_awaddr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        w_accept;
  logic        w_aw_fin;
  logic        w_w_fin;
  logic        w_b_hs;
  logic        w_trap_st;
  logic        w_unused;

  assign st_ready = (r_state == S_IDLE);
  assign w_accept = st_req && st_ready;

  assign axi.AWID    = MASTER_ID;
  assign axi.AWADDR  = r_awaddr;
  assign axi.AWLEN   = 4'd0;
  assign axi.AWSIZE  = 3'b010;
  assign axi.AWBURST = 2'b01;
  assign axi.AWVALID = (r_state == S_AW_W) && !r_aw_done;
  assign axi.WDATA   = r_wdata;
  assign axi.WSTRB   = r_wstrb;
  assign axi.WLAST   = 1'b1;
  assign axi.WVALID  = (r_state == S_AW_W) && !r_w_done;
  assign axi.BREADY  = (r_state == S_RESP);

  // A channel counts as finished once its done flag is set or it handshakes this cycle.
  assign w_aw_fin = r_aw_done || (axi.AWVALID && axi.AWREADY);
  assign w_w_fin  = r_w_done  || (axi.WVALID  && axi.WREADY);
  assign w_b_hs   = (r_state == S_RESP) && axi.BVALID;

`ifdef STORE_MISALIGN_TRAP_EN
  assign w_trap_st = (r_state == S_TRAP);
`else
  assign w_trap_st = 1'b0;
`endif

  assign st_done  = w_b_hs || w_trap_st;
  assign st_err   = (w_b_hs && (axi.BRESP != 2'b00)) || w_trap_st;
  assign w_unused = ^axi.BID;

  // Next-state selection for the store transaction sequencer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (!w_accept) begin
          w_state_nxt = S_IDLE;
        end
`ifdef STORE_MISALIGN_TRAP_EN
        else if (is_misaligned(st_func3, st_addr[1:0])) begin
          w_state_nxt = S_TRAP;
        end
`endif
        else begin
          w_state_nxt = S_AW_W;
        end
      end
      S_AW_W: begin
        if (w_aw_fin && w_w_fin) w_state_nxt = S_RESP;
        else                     w_state_nxt = S_AW_W;
      end
      S_RESP: begin
        if (axi.BVALID) w_state_nxt = S_IDLE;
        else            w_state_nxt = S_RESP;
      end
`ifdef STORE_MISALIGN_TRAP_EN
      S_TRAP:  w_state_nxt = S_IDLE;
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register and per-channel done flags (cleared whenever AW_W is left).
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state   <= S_IDLE;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_AW_W) && !(w_aw_fin && w_w_fin)) begin
        r_aw_done <= w_aw_fin;
        r_w_done  <= w_w_fin;
      end else begin
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
    end
  end

  // Payload captured at accept and held until the next accept.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_awaddr <= 32'd0;
      r_wdata  <= 32'd0;
      r_wstrb  <= 4'd0;
    end else if (w_accept) begin
      r_awaddr <= {st_addr[31:2], 2'b00};
      r_wdata  <= lane_data(st_func3, st_data);
      r_wstrb  <= lane_strb(st_func3, st_addr[1:0]);
    end else begin
      r_awaddr <= r_awaddr;
      r_wdata  <= r_wdata;
      r_wstrb  <= r_wstrb;
    end
  end

endmodule

// File: tb/tb_store_axi_writer.sv
// Randomized scoreboard bench for store_axi_writer: driver pushes model expectations, a responder
// plays the AXI slave, and a negedge monitor pops and compares on every handshake and st_done.
module tb_store_axi_writer;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    bit          trap;
    int          daw;
    int          dw;
    int          db;
    logic [1:0]  bresp;
  } txn_t;

  logic        clk = 1'b0;
  logic        ARESETn = 1'b0;
  logic        st_req = 1'b0;
  logic [31:0] st_addr = 32'd0;
  logic [31:0] st_data = 32'd0;
  logic [2:0]  st_func3 = 3'd0;
  logic        st_ready, st_done, st_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  txn_t exp_q[$];
  txn_t cfg_q[$];
  int   acc_q[$];
  int   last_done_cyc = -1;
  int   last_acc_cyc = -1;

  store_axi_writer_if #(.ID_W(4)) axi();

  store_axi_writer #(.ID_W(4), .MASTER_ID(4'd1)) dut (
    .ACLK     (clk),
    .ARESETn  (ARESETn),
    .st_req   (st_req),
    .st_addr  (st_addr),
    .st_data  (st_data),
    .st_func3 (st_func3),
    .st_ready (st_ready),
    .st_done  (st_done),
    .st_err   (st_err),
    .axi      (axi)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: lane placement from the store rules using plain arithmetic.
  function automatic txn_t model(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
    txn_t t;
    int   a;
    a      = int'(addr[1:0]);
    t.addr = addr - 32'(a);
    if (f3 == 3'd0) begin
      t.data = {24'd0, data[7:0]} * 32'h0101_0101;
      t.strb = 4'(32'd1 << a);
    end else if (f3 == 3'd1) begin
      t.data = {16'd0, data[15:0]} * 32'h0001_0001;
      t.strb = (a >= 2) ? 4'b1100 : 4'b0011;
    end else begin
      t.data = data;
      t.strb = 4'b1111;
    end
    t.trap = 1'b0;
`ifdef STORE_MISALIGN_TRAP_EN
    if (f3 == 3'd1)      t.trap = (a % 2) != 0;
    else if (f3 != 3'd0) t.trap = (a != 0);
`endif
    t.daw = 0; t.dw = 0; t.db = 0; t.bresp = 2'b00;
    return t;
  endfunction

  // Present one store; returns at posedge+1 right after it was accepted.
  task automatic issue(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data,
                       input int daw, input int dw, input int db, input logic [1:0] bresp, input bit hold);
    txn_t t;
    bit   accepted;
    t = model(f3, addr, data);
    t.daw = daw; t.dw = dw; t.db = db; t.bresp = bresp;
    exp_q.push_back(t);
    if (!t.trap) cfg_q.push_back(t);
    st_req = 1'b1; st_func3 = f3; st_addr = addr; st_data = data;
    accepted = 1'b0;
    for (int i = 0; i < 300 && !accepted; i++) begin
      @(negedge clk);
      if (st_ready) accepted = 1'b1;
    end
    if (!accepted) chk("accept_timeout", 32'(accepted), 32'd1);
    @(posedge clk); #1;
    if (!hold) st_req = 1'b0;
  endtask

  // AXI slave responder: per-transaction READY/BVALID delays taken from cfg_q front.
  initial begin
    txn_t cur;
    bit   s_bhs;
    int   aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    axi.AWREADY = 1'b0; axi.WREADY = 1'b0; axi.BVALID = 1'b0; axi.BRESP = 2'b00; axi.BID = 4'd0;
    forever begin
      @(negedge clk);
      s_bhs = axi.BVALID && axi.BREADY && ARESETn;
      @(posedge clk); #1;
      if (!ARESETn) begin
        axi.AWREADY = 1'b0; axi.WREADY = 1'b0; axi.BVALID = 1'b0; axi.BRESP = 2'b00;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      end else begin
        if (s_bhs && cfg_q.size() > 0) void'(cfg_q.pop_front());
        cur.daw = 0; cur.dw = 0; cur.db = 0; cur.bresp = 2'b00;
        if (cfg_q.size() > 0) cur = cfg_q[0];
        if (axi.AWVALID) begin axi.AWREADY = (aw_cnt >= cur.daw); aw_cnt++; end
        else begin axi.AWREADY = 1'b0; aw_cnt = 0; end
        if (axi.WVALID) begin axi.WREADY = (w_cnt >= cur.dw); w_cnt++; end
        else begin axi.WREADY = 1'b0; w_cnt = 0; end
        if (axi.BREADY) begin
          axi.BVALID = (b_cnt >= cur.db);
          axi.BRESP  = axi.BVALID ? cur.bresp : 2'b00;
          axi.BID    = 4'($urandom);
          b_cnt++;
        end else begin
          axi.BVALID = 1'b0; axi.BRESP = 2'b00; b_cnt = 0;
        end
      end
    end
  end

  // Monitor / scoreboard, sampling at negedge.
  initial begin
    txn_t        t;
    int          ac, lat, mx;
    bit          prev_aw_stall = 1'b0, prev_w_stall = 1'b0;
    bit          aw_seen = 1'b0, w_seen = 1'b0, ready_next = 1'b0;
    logic [31:0] prev_awaddr = 32'd0, prev_wdata = 32'd0;
    logic [3:0]  prev_wstrb = 4'd0;
    forever begin
      @(negedge clk);
      if (!ARESETn) begin
        prev_aw_stall = 1'b0; prev_w_stall = 1'b0;
        aw_seen = 1'b0; w_seen = 1'b0; ready_next = 1'b0;
      end else begin
        if (acc_q.size() > 0) chk("st_ready_busy", 32'(st_ready), 32'd0);
        if (ready_next) begin chk("st_ready_back", 32'(st_ready), 32'd1); ready_next = 1'b0; end
        chk("idle_quiet", 32'(st_ready && (axi.AWVALID || axi.WVALID || axi.BREADY)), 32'd0);
        if (prev_aw_stall) begin
          chk("awvalid_held", 32'(axi.AWVALID), 32'd1);
          chk("awaddr_stable", axi.AWADDR, prev_awaddr);
        end
        if (prev_w_stall) begin
          chk("wvalid_held", 32'(axi.WVALID), 32'd1);
          chk("wdata_stable", axi.WDATA, prev_wdata);
          chk("wstrb_stable", 32'(axi.WSTRB), 32'(prev_wstrb));
        end
        if (axi.AWVALID && axi.AWREADY) begin
          chk("aw_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) chk("awaddr", axi.AWADDR, exp_q[0].addr);
          chk("awid", 32'(axi.AWID), 32'd1);
          chk("aw_len_size_burst", {21'd0, axi.AWLEN, axi.AWSIZE, axi.AWBURST, 2'd0},
              {21'd0, 4'd0, 3'b010, 2'b01, 2'd0});
          aw_seen = 1'b1;
        end
        if (axi.WVALID && axi.WREADY) begin
          chk("w_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            chk("wdata", axi.WDATA, exp_q[0].data);
            chk("wstrb", 32'(axi.WSTRB), 32'(exp_q[0].strb));
          end
          chk("wlast", 32'(axi.WLAST), 32'd1);
          w_seen = 1'b1;
        end
        if (st_err) chk("err_with_done", 32'(st_done), 32'd1);
        if (st_done) begin
          chk("done_expected", 32'(exp_q.size() > 0 && acc_q.size() > 0), 32'd1);
          if (exp_q.size() > 0 && acc_q.size() > 0) begin
            t  = exp_q.pop_front();
            ac = acc_q.pop_front();
            mx = (t.daw > t.dw) ? t.daw : t.dw;
            lat = t.trap ? 1 : (2 + mx + t.db);
            chk("done_latency", 32'(cyc - ac), 32'(lat));
            chk("st_err", 32'(st_err), 32'(t.trap || (t.bresp != 2'b00)));
            chk("aw_issued", 32'(aw_seen), 32'(!t.trap));
            chk("w_issued", 32'(w_seen), 32'(!t.trap));
          end
          aw_seen = 1'b0; w_seen = 1'b0; ready_next = 1'b1;
          last_done_cyc = cyc;
        end
        if (st_req && st_ready) begin
          acc_q.push_back(cyc);
          last_acc_cyc = cyc;
        end
        prev_aw_stall = axi.AWVALID && !axi.AWREADY;
        prev_w_stall  = axi.WVALID && !axi.WREADY;
        prev_awaddr   = axi.AWADDR;
        prev_wdata    = axi.WDATA;
        prev_wstrb    = axi.WSTRB;
      end
    end
  end

  // Directed scenarios, then randomized traffic, then drain.
  initial begin
    int          d0, n_hold;
    logic [1:0]  br;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_st_ready", 32'(st_ready), 32'd1);
    chk("rst_done_err", {30'd0, st_done, st_err}, 32'd0);
    chk("rst_valids", {29'd0, axi.AWVALID, axi.WVALID, axi.BREADY}, 32'd0);
    chk("rst_awaddr", axi.AWADDR, 32'd0);
    chk("rst_wdata", axi.WDATA, 32'd0);
    chk("rst_wstrb", 32'(axi.WSTRB), 32'd0);
    @(negedge clk); #2;
    ARESETn = 1'b1;
    @(posedge clk); #1;

    issue(3'd0, 32'h0000_1003, 32'h0000_00A5, 0, 0, 0, 2'b00, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    issue(3'd1, 32'h0000_2002, 32'h1234_BEEF, 3, 0, 0, 2'b00, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    issue(3'd2, 32'h0000_3000, 32'hDEAD_BEEF, 0, 0, 5, 2'b10, 1'b0);
    repeat (10) @(posedge clk);
    #1;

    // Reset in the middle of the address/data phase.
    issue(3'd2, 32'h0000_5000, 32'h1111_2222, 20, 20, 0, 2'b00, 1'b0);
    @(negedge clk); #2;
    chk("pre_rst_awvalid", 32'(axi.AWVALID), 32'd1);
    ARESETn = 1'b0;
    #1;
    chk("async_rst_valids", {29'd0, axi.AWVALID, axi.WVALID, axi.BREADY}, 32'd0);
    chk("async_rst_ready", 32'(st_ready), 32'd1);
    exp_q.delete(); cfg_q.delete(); acc_q.delete();
    repeat (2) @(negedge clk);
    #2;
    ARESETn = 1'b1;
    @(posedge clk); #1;
    issue(3'd0, 32'h0000_6001, 32'h0000_003C, 0, 1, 1, 2'b00, 1'b0);
    repeat (8) @(posedge clk);
    #1;

    issue(3'd2, 32'h0000_4001, 32'h0BAD_F00D, 0, 0, 0, 2'b00, 1'b0);
    repeat (8) @(posedge clk);
    #1;

    // Back-to-back with st_req held high across the first completion.
    issue(3'd0, 32'h0000_7002, 32'h0000_0011, 1, 2, 1, 2'b00, 1'b1);
    issue(3'd2, 32'h0000_7004, 32'hCAFE_0001, 0, 0, 0, 2'b01, 1'b0);
    chk("b2b_accept_after_done", 32'(last_acc_cyc), 32'(last_done_cyc + 1));

    for (int n = 0; n < 40; n++) begin
      br     = ($urandom_range(3, 0) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
      n_hold = (n == 39) ? 0 : int'($urandom_range(1, 0));
      issue(3'($urandom_range(7, 0)), $urandom, $urandom,
            int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
            br, n_hold[0]);
      if (n_hold == 0) begin
        d0 = int'($urandom_range(2, 0));
        repeat (d0) @(posedge clk);
        #1;
      end
    end

    for (int i = 0; i < 500 && exp_q.size() > 0; i++) @(negedge clk);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
